// File: rtl/db_lookup_client.sv
// Lookup client: forwards parser lookups to the database and matches in-order
// responses back to caller tags, retiring the oldest request on timeout.
module db_lookup_client #(
  parameter int KEY_SIZE  = 96,
  parameter int FLAG_SIZE = 4,
  parameter int TAG_SIZE  = 8,
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [KEY_SIZE-1:0]  req_key,
  input  logic [FLAG_SIZE-1:0] req_flag,
  input  logic [TAG_SIZE-1:0]  req_tag,
  output logic                 db_valid,
  output logic [KEY_SIZE-1:0]  db_key,
  output logic [FLAG_SIZE-1:0] db_flag,
  input  logic                 db_rsp_valid,
  input  logic [FLAG_SIZE-1:0] db_rsp_flag,
  output logic                 res_valid,
  output logic [TAG_SIZE-1:0]  res_tag,
  output logic [FLAG_SIZE-1:0] res_flag,
  output logic                 res_timeout,
  output logic [15:0]          stray_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [AGE_W-1:0]     age;
  logic [TAG_SIZE-1:0]  tag_mem [DEPTH];

  logic not_empty;
  logic push;
  logic rsp_pop;
  logic timeout_pop;
  logic pop;

  assign not_empty   = (state != EMPTY);
  assign req_ready   = !rst && (state != FULL);
  assign push        = req_valid && req_ready;
  assign rsp_pop     = db_rsp_valid && not_empty;
  // A response in the timeout cycle retires the head normally instead.
  assign timeout_pop = !db_rsp_valid && not_empty && (age == AGE_W'(TIMEOUT - 1));
  assign pop         = rsp_pop || timeout_pop;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_W'(1);
    else if (pop && !push)
      count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      count <= '0;
    end else begin
      count <= count_next;
      case (state)
        EMPTY:   if (push) state <= BUSY;
        BUSY: begin
          if (count_next == '0)
            state <= EMPTY;
          else if (count_next == CNT_W'(DEPTH))
            state <= FULL;
        end
        FULL:    if (pop && !push) state <= BUSY;
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= req_tag;
  end

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || pop || !not_empty)
      age <= '0;
    else
      age <= age + AGE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_valid    <= 1'b0;
      db_key      <= '0;
      db_flag     <= '0;
      res_valid   <= 1'b0;
      res_tag     <= '0;
      res_flag    <= '0;
      res_timeout <= 1'b0;
      stray_cnt   <= '0;
    end else begin
      db_valid  <= push;
      res_valid <= pop;
      if (push) begin
        db_key  <= req_key;
        db_flag <= req_flag;
      end
      if (pop) begin
        res_tag     <= tag_mem[rd_ptr];
        res_flag    <= rsp_pop ? db_rsp_flag : '0;
        res_timeout <= timeout_pop;
      end
      if (db_rsp_valid && !not_empty && stray_cnt != 16'hFFFF)
        stray_cnt <= stray_cnt + 16'd1;
    end
  end

endmodule

// File: doc/db_lookup_client.md
DB_LOOKUP_CLIENT -- requirements
Module: db_lookup_client

Interface
REQ-001 SHALL have parameter KEY_SIZE, default 96, lookup key width (src IP 32, dst IP 32, dst UDP port 16, reserved 16).
REQ-002 SHALL have parameter FLAG_SIZE, default 4, operation/result flag width.
REQ-003 SHALL have parameter TAG_SIZE, default 8, caller-supplied request tag width.
REQ-004 SHALL have parameter DEPTH, default 8, max outstanding lookups (power of 2, >=2).
REQ-005 SHALL have parameter TIMEOUT, default 64, cycles to wait for a response before retiring the oldest request.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 req_valid  in  1  parser offers a lookup.
REQ-009 req_ready  out  1  block accepts the lookup this cycle.
REQ-010 req_key  in  KEY_SIZE  lookup key.
REQ-011 req_flag  in  FLAG_SIZE  operation code.
REQ-012 req_tag  in  TAG_SIZE  caller tag, returned with result.
REQ-013 db_valid  out  1  one-cycle lookup strobe to database.
REQ-014 db_key  out  KEY_SIZE  key to database.
REQ-015 db_flag  out  FLAG_SIZE  operation to database.
REQ-016 db_rsp_valid  in  1  database result strobe; results return in issue order.
REQ-017 db_rsp_flag  in  FLAG_SIZE  database result flag.
REQ-018 res_valid  out  1  one-cycle result strobe to caller.
REQ-019 res_tag  out  TAG_SIZE  tag of retired request.
REQ-020 res_flag  out  FLAG_SIZE  result flag; 0 on timeout.
REQ-021 res_timeout  out  1  retired by timeout, not by response.
REQ-022 stray_cnt  out  16  count of responses received with nothing outstanding.

Function
REQ-023 Accept = req_valid & req_ready; req_ready SHALL be combinational: 1 when outstanding count < DEPTH, 0 when count == DEPTH.
REQ-024 On accept, db_valid/db_key/db_flag SHALL be driven registered the next cycle (latency 1); db_valid low otherwise; db_key/db_flag hold last value.
REQ-025 On accept, req_tag SHALL be pushed into an in-order tag FIFO of DEPTH entries with wrap-around pointers.
REQ-026 On db_rsp_valid with count > 0, head tag SHALL be popped; next cycle res_valid=1, res_tag=head, res_flag=db_rsp_flag, res_timeout=0.
REQ-027 On db_rsp_valid with count == 0, nothing popped, no res_valid, stray_cnt +1 saturating at 0xFFFF.
REQ-028 Age counter SHALL count cycles while count > 0; cleared on any pop, held at 0 while empty; starts counting the cycle after the first push into an empty FIFO.
REQ-029 When age counter reaches TIMEOUT-1 and no db_rsp_valid that cycle, head SHALL be popped; next cycle res_valid=1, res_tag=head, res_flag=0, res_timeout=1.
REQ-030 Response and timeout in the same cycle: response wins; single pop; res_timeout=0.
REQ-031 Simultaneous accept and pop: count unchanged; accept permitted when count == DEPTH only if a pop occurs that cycle is NOT allowed (req_ready stays 0 at full).
REQ-032 State machine: EMPTY (count 0), BUSY (0<count<DEPTH), FULL (count DEPTH); transitions on net push/pop only; push at EMPTY -> BUSY, pop of last entry -> EMPTY, push reaching DEPTH -> FULL, pop at FULL -> BUSY.
REQ-033 At most one pop and one push per cycle; res_valid never asserted two consecutive results in one cycle.

Reset
REQ-034 During rst: req_ready=0, db_valid=0, db_key=0, db_flag=0, res_valid=0, res_tag=0, res_flag=0, res_timeout=0, stray_cnt=0, FIFO empty, age=0, state EMPTY.
REQ-035 rst asserted mid-operation SHALL discard all outstanding tags without emitting results; responses arriving the cycle after deassert count as stray.
REQ-036 req_ready SHALL be 1 the first cycle after rst deasserts.

Verification
REQ-037 Single lookup: key=0x0A000001_0A000002_1F90_0000, flag=1, tag=0x11 accepted; db_rsp_valid with flag=2 three cycles later -> db_valid one cycle after accept, res_valid with tag=0x11, flag=2, timeout=0.
REQ-038 Fill: 8 back-to-back accepts tags 0..7 with no response -> req_ready=0 after 8th; 9th held; one response -> req_ready=1 next cycle, res_tag=0.
REQ-039 Timeout: one accept tag=0x55, no response -> res_valid TIMEOUT cycles after first age count with tag=0x55, flag=0, timeout=1; FIFO empty.
REQ-040 Collision: response arrives in the exact cycle age hits TIMEOUT-1 -> single result, timeout=0, flag=response flag.
REQ-041 Stray: db_rsp_valid with empty FIFO 3 times -> stray_cnt=3, no res_valid.
REQ-042 Reset mid-flight: 4 outstanding, rst 1 cycle -> no res_valid, req_ready=1 after reset, later responses increment stray_cnt.
